// File: rtl/audio_i2s_sequencer_pkg.sv
// Shared definitions for the Pocket I2S audio sequencer: slot indices,
// sequencer states and the stereo sample container.
package audio_i2s_sequencer_pkg;

  // Default sample width; the sequencer's SAMPLE_W parameter defaults to it.
  localparam int AUD_SAMPLE_W = 16;

  // Word-select level for each channel slot.
  localparam logic SLOT_LEFT  = 1'b0;
  localparam logic SLOT_RIGHT = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic [AUD_SAMPLE_W-1:0] l;
    logic [AUD_SAMPLE_W-1:0] r;
  } stereo_t;

endpackage

// File: rtl/audio_i2s_sequencer_clkgen.sv
// I2S bit/frame timing: mclk divider, bit-in-frame counter, SCLK and LRCK
// generation, plus the shift (SCLK falling) and frame-start strobes.
module audio_i2s_sequencer_clkgen
  import audio_i2s_sequencer_pkg::*;
#(
  parameter int MCLK_PER_SCLK = 4,
  parameter int SLOT_BITS     = 32,
  parameter int BIT_W         = $clog2(2 * SLOT_BITS)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  output logic             sclk_o,
  output logic             lrck_o,
  output logic             shift_o,
  output logic             fs_o,
  output logic [BIT_W-1:0] bit_nxt_o
);

  localparam int DIV_W = (MCLK_PER_SCLK > 1) ? $clog2(MCLK_PER_SCLK) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             sclk_q, sclk_d;
  logic             lrck_q, lrck_d;
  logic             div_wrap_s;
  logic             bit_wrap_s;

  // Next-state for the counters and the registered SCLK / LRCK levels.
  always_comb begin
    div_wrap_s = (div_q == DIV_W'(MCLK_PER_SCLK - 1));
    bit_wrap_s = (bit_q == BIT_W'(2 * SLOT_BITS - 1));
    div_d      = div_q;
    bit_d      = bit_q;
    if (div_wrap_s) begin
      div_d = {DIV_W{1'b0}};
      if (bit_wrap_s) begin
        bit_d = {BIT_W{1'b0}};
      end else begin
        bit_d = bit_q + BIT_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      bit_d = bit_q;
    end
    // SCLK low for the first half of each bit period, high for the second.
    sclk_d = (div_d >= DIV_W'(MCLK_PER_SCLK / 2));
    // LRCK follows the bit counter, so it only moves on the SCLK falling edge.
    if (bit_d >= BIT_W'(SLOT_BITS)) begin
      lrck_d = SLOT_RIGHT;
    end else begin
      lrck_d = SLOT_LEFT;
    end
  end

  // Counter and clock-output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q  <= {DIV_W{1'b0}};
      bit_q  <= {BIT_W{1'b0}};
      sclk_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sclk_q <= sclk_d;
      lrck_q <= lrck_d;
    end
  end

  assign sclk_o    = sclk_q;
  assign lrck_o    = lrck_q;
  assign shift_o   = div_wrap_s;
  assign fs_o      = div_wrap_s & bit_wrap_s;
  assign bit_nxt_o = bit_d;

endmodule

// File: rtl/audio_i2s_sequencer.sv
// Pocket I2S DAC sequencer: stages one stereo sample per 48 kHz frame from
// the CDC FIFO, repeats the last sample on underrun and serializes it.
module audio_i2s_sequencer
  import audio_i2s_sequencer_pkg::*;
#(
  parameter int MCLK_PER_SCLK = 4,
  parameter int SLOT_BITS     = 32,
  parameter int SAMPLE_W      = AUD_SAMPLE_W
) (
  input  logic                audio_mclk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_l,
  input  logic [SAMPLE_W-1:0] in_r,
  input  logic                mute,
  output logic                sample_req,
  output logic                audio_sclk,
  output logic                audio_lrck,
  output logic                audio_dac,
  output logic [7:0]          underrun_cnt
);

  localparam int BIT_W = $clog2(2 * SLOT_BITS);

  logic             shift_s;
  logic             fs_s;
  logic [BIT_W-1:0] bit_nxt_s;
  logic             load_s;
  logic             underrun_s;

  seq_state_e state_q, state_d;
  stereo_t    stg_q;
  stereo_t    frame_q;
  logic       stg_full_q;
  logic       mute_q;
  logic       sreq_q;
  logic       dac_q, dac_d;
  logic [7:0] urun_q;

  // Serial bit for slot position b of frame f: delay bit, MSB-first sample, zero pad.
  function automatic logic slot_bit(input stereo_t f, input logic [BIT_W-1:0] b);
    logic [BIT_W-1:0]    pos;
    logic [SAMPLE_W-1:0] smp;
    logic [SAMPLE_W-1:0] shifted;
    logic                res;
    if (b >= BIT_W'(SLOT_BITS)) begin
      pos = b - BIT_W'(SLOT_BITS);
      smp = f.r;
    end else begin
      pos = b;
      smp = f.l;
    end
    shifted = smp << (pos - BIT_W'(1));
    if ((pos >= BIT_W'(1)) && (pos <= BIT_W'(SAMPLE_W))) begin
      res = shifted[SAMPLE_W-1];
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

  audio_i2s_sequencer_clkgen #(
    .MCLK_PER_SCLK (MCLK_PER_SCLK),
    .SLOT_BITS     (SLOT_BITS),
    .BIT_W         (BIT_W)
  ) u_i2s_clkgen (
    .clk_i     (audio_mclk),
    .rst_ni    (reset_n),
    .sclk_o    (audio_sclk),
    .lrck_o    (audio_lrck),
    .shift_o   (shift_s),
    .fs_o      (fs_s),
    .bit_nxt_o (bit_nxt_s)
  );

  // FSM state register.
  always_ff @(posedge audio_mclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: leave IDLE at the first frame start that finds a staged sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fs_s && stg_full_q) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: frame-start load decision uses stg_full from before this cycle.
  always_comb begin
    load_s     = 1'b0;
    underrun_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        load_s     = fs_s & stg_full_q;
        underrun_s = 1'b0;
      end
      ST_RUN: begin
        load_s     = fs_s & stg_full_q;
        underrun_s = fs_s & ~stg_full_q;
      end
      default: begin
        load_s     = 1'b0;
        underrun_s = 1'b0;
      end
    endcase
  end

  // Staging register: a new strobe always wins, even on a consuming frame start.
  always_ff @(posedge audio_mclk or negedge reset_n) begin
    if (!reset_n) begin
      stg_q      <= '0;
      stg_full_q <= 1'b0;
    end else if (in_valid) begin
      stg_q      <= {in_l, in_r};
      stg_full_q <= 1'b1;
    end else if (load_s) begin
      stg_full_q <= 1'b0;
    end
  end

  // Frame register and per-frame mute capture, both updated only at frame start.
  always_ff @(posedge audio_mclk or negedge reset_n) begin
    if (!reset_n) begin
      frame_q <= '0;
      mute_q  <= 1'b0;
    end else if (fs_s) begin
      mute_q <= mute;
      if (load_s) begin
        frame_q <= stg_q;
      end
    end
  end

  // Saturating count of frames that started without a fresh sample.
  always_ff @(posedge audio_mclk or negedge reset_n) begin
    if (!reset_n) begin
      urun_q <= 8'h00;
    end else if (underrun_s && (urun_q != 8'hFF)) begin
      urun_q <= urun_q + 8'h01;
    end
  end

  // Serializer: pick the next slot bit on each SCLK falling edge.
  always_comb begin
    dac_d = dac_q;
    if (shift_s) begin
      if ((state_q == ST_RUN) && !mute_q) begin
        dac_d = slot_bit(frame_q, bit_nxt_s);
      end else begin
        dac_d = 1'b0;
      end
    end else begin
      dac_d = dac_q;
    end
  end

  // Registered serial data and FIFO request pulse.
  always_ff @(posedge audio_mclk or negedge reset_n) begin
    if (!reset_n) begin
      dac_q  <= 1'b0;
      sreq_q <= 1'b0;
    end else begin
      dac_q  <= dac_d;
      sreq_q <= fs_s;
    end
  end

  assign sample_req   = sreq_q;
  assign audio_dac    = dac_q;
  assign underrun_cnt = urun_q;

endmodule

// File: tb/tb_audio_i2s_sequencer.sv
// Self-checking bench for audio_i2s_sequencer: a frame-level model pushes the
// expected 64-bit frame at each frame start; the frame is popped when the DUT
// begins playing it and compared bit by bit on audio_dac.
module tb_audio_i2s_sequencer;

  localparam int M     = 4;
  localparam int S     = 32;
  localparam int W     = 16;
  localparam int FRAME = M * 2 * S;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_l = 16'h0000;
  logic [W-1:0] in_r = 16'h0000;
  logic         mute = 1'b0;
  logic         sample_req;
  logic         audio_sclk;
  logic         audio_lrck;
  logic         audio_dac;
  logic [7:0]   underrun_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cur = 64'd0;

  // Reference model state
  logic [31:0] m_stg   = 32'd0;
  logic [31:0] m_frame = 32'd0;
  logic        m_full  = 1'b0;
  logic        m_run   = 1'b0;
  int          m_urun  = 0;
  logic        mute_lvl = 1'b0;

  audio_i2s_sequencer #(
    .MCLK_PER_SCLK (M),
    .SLOT_BITS     (S),
    .SAMPLE_W      (W)
  ) dut (
    .audio_mclk   (clk),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .in_l         (in_l),
    .in_r         (in_r),
    .mute         (mute),
    .sample_req   (sample_req),
    .audio_sclk   (audio_sclk),
    .audio_lrck   (audio_lrck),
    .audio_dac    (audio_dac),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Expected frame, index = slot bit number; lr = {left, right}.
  function automatic logic [63:0] build(input logic [31:0] lr);
    logic [63:0] f;
    f = 64'd0;
    for (int k = 0; k < 16; k++) begin
      f[1 + k]  = lr[31 - k];
      f[33 + k] = lr[15 - k];
    end
    return f;
  endfunction

  // One mclk cycle: drive inputs, advance the model, clock, then check outputs.
  task automatic step(input logic v, input logic [W-1:0] l, input logic [W-1:0] r, input logic m);
    logic fs;
    int   j;
    in_valid = v;
    in_l     = l;
    in_r     = r;
    mute     = m;
    fs = (((cyc + 1) % FRAME) == 0);
    if (fs) begin
      if (m_full) begin
        m_frame = m_stg;
        m_full  = 1'b0;
        m_run   = 1'b1;
      end else if (m_run) begin
        if (m_urun != 255) m_urun++;
      end
      exp_q.push_back((m_run && !m) ? build(m_frame) : 64'd0);
    end
    if (v) begin
      m_stg  = {l, r};
      m_full = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    in_valid = 1'b0;
    if ((cyc % FRAME) == 0) begin
      chk_eq("sb_depth", 64'(exp_q.size()), 64'd1);
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = 64'd0;
    end
    j = (cyc % FRAME) / M;
    chk_eq("ctl", 64'({sample_req, audio_sclk, audio_lrck}),
           64'({((cyc % FRAME) == 0), ((cyc % M) >= (M / 2)), (j >= S)}));
    chk_eq("dac", 64'(audio_dac), 64'(cur[j]));
    chk_eq("urun", 64'(underrun_cnt), 64'(m_urun));
  endtask

  task automatic idle_until(input int c);
    while (cyc < c) step(1'b0, 16'h0000, 16'h0000, mute_lvl);
  endtask

  task automatic do_reset(input bit imm, input int hold);
    reset_n = 1'b0;
    #1;
    if (imm)
      chk_eq("rst_async", 64'({sample_req, audio_sclk, audio_lrck, audio_dac, underrun_cnt}), 64'd0);
    repeat (hold) @(posedge clk);
    #1;
    chk_eq("rst_hold", 64'({sample_req, audio_sclk, audio_lrck, audio_dac, underrun_cnt}), 64'd0);
    m_stg   = 32'd0;
    m_frame = 32'd0;
    m_full  = 1'b0;
    m_run   = 1'b0;
    m_urun  = 0;
    exp_q.delete();
    cur     = 64'd0;
    cyc     = 0;
    reset_n = 1'b1;
  endtask

  initial begin
    do_reset(1'b0, 3);
    // Idle through the first frame start, then stage 0x8001 / 0x7FFE.
    idle_until(300);
    step(1'b1, 16'h8001, 16'h7FFE, 1'b0);
    // Load at 512, then three underrun frames.
    idle_until(1535);
    chk_eq("urun3", 64'(underrun_cnt), 64'd3);
    // New sample strobed exactly on the frame start with nothing staged.
    step(1'b1, 16'h1234, 16'hABCD, 1'b0);
    chk_eq("urun_fs", 64'(underrun_cnt), 64'd4);
    // Overwrite a staged sample, then mute across the consuming frame start.
    idle_until(1900);
    step(1'b1, 16'h1111, 16'h2222, 1'b0);
    idle_until(1950);
    step(1'b1, 16'h5A5A, 16'hC3C3, 1'b0);
    mute_lvl = 1'b1;
    idle_until(2100);
    chk_eq("urun_mute", 64'(underrun_cnt), 64'd4);
    mute_lvl = 1'b0;
    // Long starvation drives the counter into saturation.
    idle_until(2304 + 260 * FRAME);
    chk_eq("urun_sat", 64'(underrun_cnt), 64'd255);
    // Stage a sample, then reset at bit 40 of the frame.
    step(1'b1, 16'h0F0F, 16'hF0F0, 1'b0);
    idle_until(2304 + 260 * FRAME + 160);
    do_reset(1'b1, 2);
    idle_until(2 * FRAME + 40);
    chk_eq("urun_post_rst", 64'(underrun_cnt), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
